muldiv_issue_ctrl: RTL and testbench

MULDIV_ISSUE_CTRL -- requirements
Module: muldiv_issue_ctrl

---
 rtl/muldiv_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Issues MULT/DIV/MFHI/MFLO to a multi-cycle mult/div unit; MF reads are combinational, starts take 1 cycle.
// While an operation is in flight any new request is stalled until the first idle cycle; flush never aborts it.
module muldiv_issue_ctrl #(
  parameter int MULT_LAT = 16,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Op_valid_i,
  input  logic [1:0]  Op_kind_i,
  input  logic [31:0] Rs_i,
  input  logic [31:0] Rt_i,
  input  logic        Flush_i,
  output logic [4:1]  ALUCtl_o,
  output logic [31:0] Op1_o,
  output logic [31:0] Op2_o,
  input  logic        Stall_i,
  input  logic [31:0] Res_i,
  output logic        Stall_o,
  output logic [31:0] Res_o,
  output logic        Res_valid_o,
  output logic        Busy_o,
  output logic        Err_o
);

  localparam int CW = $clog2(DIV_LAT) + 1;
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

  localparam logic [4:1] CMD_NOP  = 4'b0000;
  localparam logic [4:1] CMD_MULT = 4'b1100;
  localparam logic [4:1] CMD_DIV  = 4'b1101;
  localparam logic [4:1] CMD_MFHI = 4'b1000;
  localparam logic [4:1] CMD_MFLO = 4'b1010;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          req;
  logic          start;
  logic [4:1]    alu_ctl;
  logic [31:0]   op1, op2, res;
  logic          stall, res_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    alu_ctl = CMD_NOP;
    op1     = '0;
    op2     = '0;
    res     = '0;
    stall   = 1'b0;
    res_vld = 1'b0;
    start   = 1'b0;
    req     = Op_valid_i && !Flush_i;

    case (state_q)
      IDLE: begin
        if (req) begin
          case (Op_kind_i)
            2'b00: begin
              alu_ctl = CMD_MULT;
              start   = 1'b1;
              cnt_d   = MULT_CNT;
            end
            2'b01: begin
              alu_ctl = CMD_DIV;
              start   = 1'b1;
              cnt_d   = DIV_CNT;
            end
            2'b10: begin
              alu_ctl = CMD_MFHI;
              res     = Res_i;
              res_vld = 1'b1;
            end
            default: begin
              alu_ctl = CMD_MFLO;
              res     = Res_i;
              res_vld = 1'b1;
            end
          endcase
          if (start) begin
            op1     = Rs_i;
            op2     = Rt_i;
            state_d = BUSY;
          end
        end
        // The unit must never report busy unless we just commanded it.
        if (Stall_i && !start) begin
          err_d = 1'b1;
        end
      end
      default: begin
        stall = req;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State flops clear asynchronously, but the combinational decode must be silenced too.
  assign ALUCtl_o    = rst_i ? CMD_NOP : alu_ctl;
  assign Op1_o       = rst_i ? '0 : op1;
  assign Op2_o       = rst_i ? '0 : op2;
  assign Stall_o     = !rst_i && stall;
  assign Res_o       = rst_i ? '0 : res;
  assign Res_valid_o = !rst_i && res_vld;
  assign Busy_o      = (state_q == BUSY);
  assign Err_o       = err_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a simple signed mult/div unit model behind it.
module tb_muldiv_issue_ctrl;

  localparam int MULT_LAT = 16;
  localparam int DIV_LAT  = 32;

  localparam logic [1:0] K_MULT = 2'b00;
  localparam logic [1:0] K_DIV  = 2'b01;
  localparam logic [1:0] K_MFHI = 2'b10;
  localparam logic [1:0] K_MFLO = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_kind;
  logic [31:0] rs, rt;
  logic        flush;
  logic [4:1]  alu;
  logic [31:0] op1, op2;
  logic        stall_i;
  logic [31:0] res_i;
  logic        stall_o;
  logic [31:0] res_o;
  logic        res_vld;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .Op_valid_i(op_valid), .Op_kind_i(op_kind),
    .Rs_i(rs), .Rt_i(rt), .Flush_i(flush), .ALUCtl_o(alu), .Op1_o(op1), .Op2_o(op2),
    .Stall_i(stall_i), .Res_i(res_i), .Stall_o(stall_o), .Res_o(res_o),
    .Res_valid_o(res_vld), .Busy_o(busy), .Err_o(err)
  );

  // Mult/div unit model: results become final LAT cycles after the start edge.
  logic [31:0]        m_hi, m_lo, p_hi, p_lo;
  logic [5:0]         m_cnt;
  logic signed [63:0] a64, b64, prod;
  logic [31:0]        quo, rem;
  logic               stall_force;
  logic               res_ovr_en;
  logic [31:0]        res_ovr;

  assign a64  = {{32{op1[31]}}, op1};
  assign b64  = {{32{op2[31]}}, op2};
  assign prod = a64 * b64;
  assign quo  = (op2 == 32'd0) ? 32'd0 : 32'($signed(op1) / $signed(op2));
  assign rem  = (op2 == 32'd0) ? 32'd0 : 32'($signed(op1) % $signed(op2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0;
      m_hi  <= '0;
      m_lo  <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else if (alu == 4'b1100) begin
      m_cnt <= 6'(MULT_LAT - 1);
      p_hi  <= prod[63:32];
      p_lo  <= prod[31:0];
      m_hi  <= 32'hDEADBEEF;
      m_lo  <= 32'hDEADBEEF;
    end else if (alu == 4'b1101) begin
      m_cnt <= 6'(DIV_LAT - 1);
      p_hi  <= rem;
      p_lo  <= quo;
      m_hi  <= 32'hDEADBEEF;
      m_lo  <= 32'hDEADBEEF;
    end else if (m_cnt != 6'd0) begin
      m_cnt <= m_cnt - 6'd1;
      if (m_cnt == 6'd1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end
  end

  assign stall_i = stall_force || (m_cnt != 6'd0);
  assign res_i   = res_ovr_en ? res_ovr :
                   (alu == 4'b1000) ? m_hi :
                   (alu == 4'b1010) ? m_lo : 32'd0;

  typedef struct {
    logic        v;
    logic [1:0]  k;
    logic        fl;
    logic [3:0]  e_alu;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic        e_stall;
    logic        e_rv;
    logic [31:0] e_res;
    logic        e_busy;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    op_valid = v;
    op_kind  = k;
    rs       = a;
    rt       = b;
    flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Returns at the negedge of the first non-stalled cycle.
  task automatic count_stall(output int n, output int cmds);
    n    = 0;
    cmds = 0;
    @(negedge clk);
    while (stall_o && n < 200) begin
      n++;
      if (alu != 4'b0000) cmds++;
      step();
      @(negedge clk);
    end
  endtask

  task automatic mult_mflo_seq(input string tag);
    int n, c;
    drive(1'b1, K_MULT, 32'd7, 32'hFFFFFFFD, 1'b0);
    @(negedge clk);
    chk({tag, " start alu"}, {28'd0, alu}, 32'h0000000C);
    chk({tag, " start op1"}, op1, 32'd7);
    chk({tag, " start op2"}, op2, 32'hFFFFFFFD);
    chk({tag, " start stall"}, {31'd0, stall_o}, 32'd0);
    step();
    drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b0);
    count_stall(n, c);
    chk({tag, " stall cycles"}, n, MULT_LAT - 1);
    chk({tag, " cmds while stalled"}, c, 32'd0);
    chk({tag, " mflo alu"}, {28'd0, alu}, 32'h0000000A);
    chk({tag, " mflo vld"}, {31'd0, res_vld}, 32'd1);
    chk({tag, " mflo res"}, res_o, 32'hFFFFFFEB);
    step();
    drive(1'b1, K_MFHI, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk({tag, " mfhi res"}, res_o, 32'hFFFFFFFF);
    chk({tag, " mfhi stall"}, {31'd0, stall_o}, 32'd0);
    step();
    drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, c, bcnt;

    tbl[0] = '{1'b0, K_MULT, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b1, K_MULT, 1'b0, 4'hC, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{1'b1, K_DIV,  1'b0, 4'hD, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[3] = '{1'b1, K_MFHI, 1'b0, 4'h8, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0};
    tbl[4] = '{1'b1, K_MFLO, 1'b0, 4'hA, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0};
    tbl[5] = '{1'b1, K_DIV,  1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[6] = '{1'b1, K_MFLO, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[7] = '{1'b0, K_MFHI, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};

    stall_force = 1'b0;
    res_ovr_en  = 1'b0;
    res_ovr     = 32'h12345678;
    rst         = 1'b1;
    drive(1'b1, K_DIV, 32'd5, 32'd6, 1'b0);

    // Outputs under reset even with a request present.
    @(negedge clk);
    chk("rst alu", {28'd0, alu}, 32'd0);
    chk("rst op1", op1, 32'd0);
    chk("rst op2", op2, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst res_vld", {31'd0, res_vld}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
    step();

    res_ovr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].k, 32'h11111111, 32'h22222222, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d alu", i), {28'd0, alu}, {28'd0, tbl[i].e_alu});
      chk($sformatf("vec%0d op1", i), op1, tbl[i].e_op1);
      chk($sformatf("vec%0d op2", i), op2, tbl[i].e_op2);
      chk($sformatf("vec%0d stall", i), {31'd0, stall_o}, {31'd0, tbl[i].e_stall});
      chk($sformatf("vec%0d res_vld", i), {31'd0, res_vld}, {31'd0, tbl[i].e_rv});
      chk($sformatf("vec%0d res", i), res_o, tbl[i].e_res);
      step();
      drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      if (busy) do_reset();
    end
    res_ovr_en = 1'b0;

    mult_mflo_seq("mult7x-3");

    // DIV 100/7 then MFHI (remainder) and MFLO (quotient).
    drive(1'b1, K_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    chk("div start alu", {28'd0, alu}, 32'h0000000D);
    step();
    drive(1'b1, K_MFHI, 32'd0, 32'd0, 1'b0);
    count_stall(n, c);
    chk("div stall cycles", n, DIV_LAT - 1);
    chk("div mfhi res", res_o, 32'd2);
    chk("div mfhi vld", {31'd0, res_vld}, 32'd1);
    step();
    drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("div mflo res", res_o, 32'd14);
    step();

    // MULT, long gap, MFLO must not stall.
    drive(1'b1, K_MULT, 32'd2, 32'd3, 1'b0);
    step();
    drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
    repeat (20) step();
    drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("gap mflo stall", {31'd0, stall_o}, 32'd0);
    chk("gap mflo vld", {31'd0, res_vld}, 32'd1);
    chk("gap mflo res", res_o, 32'd6);
    step();

    // MULT then DIV back-to-back: DIV held, issued once on first idle cycle.
    drive(1'b1, K_MULT, 32'd3, 32'd5, 1'b0);
    step();
    drive(1'b1, K_DIV, 32'd100, 32'd7, 1'b0);
    count_stall(n, c);
    chk("b2b stall cycles", n, MULT_LAT - 1);
    chk("b2b cmds while stalled", c, 32'd0);
    chk("b2b div alu", {28'd0, alu}, 32'h0000000D);
    chk("b2b div op1", op1, 32'd100);
    chk("b2b div op2", op2, 32'd7);
    step();
    drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("b2b busy after div", {31'd0, busy}, 32'd1);
    chk("b2b no second start", {28'd0, alu}, 32'd0);
    step();
    drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b0);
    count_stall(n, c);
    chk("b2b mflo stall", n, DIV_LAT - 2);
    chk("b2b mflo res", res_o, 32'd14);
    step();

    // Flush during BUSY: no abort, stall suppressed that cycle.
    drive(1'b1, K_DIV, 32'd9, 32'd2, 1'b0);
    step();
    bcnt = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b1);
      else drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      if (busy) bcnt++;
      if (i == 5) begin
        chk("flush busy stall", {31'd0, stall_o}, 32'd0);
        chk("flush busy vld", {31'd0, res_vld}, 32'd0);
      end
      step();
    end
    chk("flush busy cycles", bcnt, DIV_LAT);
    drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("flush after res", res_o, 32'd4);
    step();

    // Reset in the middle of a DIV.
    drive(1'b1, K_DIV, 32'd100, 32'd7, 1'b0);
    step();
    drive(1'b1, K_MFLO, 32'd0, 32'd0, 1'b0);
    repeat (4) step();
    drive(1'b1, K_MULT, 32'd1, 32'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst alu", {28'd0, alu}, 32'd0);
    chk("midrst op1", op1, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    chk("midrst res_vld", {31'd0, res_vld}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, K_MULT, 32'd0, 32'd0, 1'b0);
    step();
    mult_mflo_seq("postrst");
    chk("err clean", {31'd0, err}, 32'd0);

    // Sticky error: unit busy while idle and not commanded.
    stall_force = 1'b1;
    step();
    stall_force = 1'b0;
    @(negedge clk);
    chk("err set", {31'd0, err}, 32'd1);
    step();
    @(negedge clk);
    chk("err sticky", {31'd0, err}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("err cleared", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
